serial_frame_rx: RTL
====================

// Module: serial_frame_rx
// PURPOSE
//  Downstream consumer of the 4-stage serial shift register's data_out bit stream.
//  Hunts the stream for a sync word, then deserialises a DATA_WIDTH payload
//  MSB-first, plus an optional even-parity bit.
//  Presents each completed frame on a registered valid/ready output port.
//  Feeds the lab FSM / display logic with whole bytes instead of raw bits.
// PARAMETERS
//  SYNC_WIDTH    4        width of sync word
//  SYNC_PATTERN  4'b1011  sync word, MSB = earliest received bit
//  DATA_WIDTH    8        payload bits per frame
//  PARITY_EN     1        1: one even-parity bit follows payload; 0: no parity bit
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst          in   1           reset rst, synchronous, active-high
//  bit_en       in   1           qualifies data_in; a bit is consumed only when 1
//  data_in      in   1           serial bit (from shift register data_out)
//  frame_data   out  DATA_WIDTH  last completed payload
//  frame_valid  out  1           frame_data/parity_err valid; held until accepted
//  frame_ready  in   1           consumer accepts frame when frame_valid & frame_ready
//  parity_err   out  1           parity of delivered frame failed (0 if PARITY_EN=0)
//  overrun      out  1           1-cycle pulse: completed frame dropped, output occupied
//  busy         out  1           1 while state != HUNT
// BEHAVIOUR
//  Reset: state=HUNT; history, payload shift reg and bit counter cleared.
//  Reset outputs: frame_data=0, frame_valid=0, parity_err=0, overrun=0, busy=0.
//  Reset mid-frame aborts the frame; no partial data is ever delivered.
//  Cycles with bit_en=0 change nothing except the output handshake and the overrun clear.
//  HUNT: each bit_en shifts data_in into SYNC_WIDTH history (LSB = newest).
//   - When {history[SYNC_WIDTH-2:0],data_in}==SYNC_PATTERN -> PAYLOAD.
//   - On that transition: count=0 and history cleared (no overlapping sync reuse).
//  PAYLOAD: each bit_en shifts data_in into the payload register LSB, so the first bit ends up as MSB.
//   - count increments per bit.
//   - On the DATA_WIDTH-th bit: -> PARITY if PARITY_EN, else COMPLETE action, then -> HUNT.
//  PARITY: on bit_en, perr = ^{payload,data_in} (nonzero = error).
//   - Then COMPLETE action, then -> HUNT.
//  COMPLETE action, on the same edge as the final bit:
//   - If the output slot is free (!frame_valid) or being emptied (frame_valid & frame_ready):
//     load frame_data and parity_err, set frame_valid=1.
//   - Else drop the new frame: old frame unchanged, overrun=1 for exactly one cycle.
//  Latency: frame_valid rises on the clk edge that samples the final bit (registered output).
//   - Visible the cycle after that bit_en cycle.
//  Handshake: frame_valid stays high and frame_data stable until frame_valid & frame_ready.
//   - Valid drops the following cycle unless a new frame completes on the accepting edge.
//   - On a new frame completing on the accepting edge: valid stays 1, new data loaded, no overrun.
//  frame_ready while !frame_valid is ignored.
//  Parity-failed frames are still delivered, with parity_err=1.
//  Counter width: $clog2(DATA_WIDTH+1); no wrap inside a frame.
//  Next sync search starts fresh after each frame.
//  busy = (state != HUNT), combinational from state register.
// TESTING
//  1) Sync + data:
//     - Stimulus: bit_en=1 continuous, stream 1011 | 10100101 | 0, frame_ready=1.
//     - Response: frame_data=8'hA5, parity_err=0.
//     - frame_valid high exactly 1 cycle, 1 cycle after the parity bit.
//  2) Parity error: same stream with parity bit=1 -> frame_data=8'hA5, parity_err=1.
//  3) Back-pressure and overrun:
//     - Stimulus: frame_ready=0; send frame 8'h3C then frame 8'hC3.
//     - Response: frame_data stays 8'h3C; overrun pulses 1 cycle when 8'hC3 completes.
//     - Then raise frame_ready -> 8'h3C accepted, frame_valid falls.
//  4) Gaps and false sync:
//     - Stimulus: bit_en toggling 1/0, stream 101 0 1011 | 8'h5A | 0.
//     - Response: single frame 8'h5A; busy=1 only from sync match to frame end.
//  5) Reset mid-frame:
//     - Stimulus: assert rst after sync + 4 payload bits, then send full frame 8'hFF + parity 0.
//     - Response: only 8'hFF delivered; all outputs 0 the cycle after rst.
//  6) Simultaneous accept and complete:
//     - Stimulus: frame_ready asserted on the exact edge the second frame's last bit is sampled.
//     - Response: valid stays 1, new data shown, overrun=0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a serial bit stream for a sync word, deserialises an
// MSB-first payload plus optional even-parity bit, and presents each completed
// frame on a registered valid/ready output slot.
//
// Output handshake: frame_valid rises on the edge that samples a frame's final
// bit and then holds, with frame_data/parity_err stable, until an edge where
// frame_valid & frame_ready are both high. frame_ready is ignored while
// frame_valid is low. A frame completing while the slot is full and not being
// emptied is dropped and overrun pulses for one cycle. A frame completing on
// the accepting edge replaces the accepted one and valid stays high.
module serial_frame_rx #(
    parameter int                    SYNC_WIDTH   = 4,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b1011,
    parameter int                    DATA_WIDTH   = 8,
    parameter bit                    PARITY_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_WIDTH-1:0]   r_history;
    logic [SYNC_WIDTH-1:0]   w_history_nxt;
    logic [SYNC_WIDTH-1:0]   w_history_shift;
    logic [DATA_WIDTH-1:0]   r_payload;
    logic [DATA_WIDTH-1:0]   w_payload_nxt;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_nxt;
    logic                    w_complete;
    logic [DATA_WIDTH-1:0]   w_done_data;
    logic                    w_done_perr;
    logic [DATA_WIDTH-1:0]   r_frame_data;
    logic                    r_frame_valid;
    logic                    r_parity_err;
    logic                    r_overrun;

    assign w_history_shift = {r_history[SYNC_WIDTH-2:0], data_in};

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, sync history, payload shift and frame-completion decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_history_nxt = r_history;
        w_payload_nxt = r_payload;
        w_count_nxt   = r_count;
        w_complete    = 1'b0;
        w_done_data   = r_payload;
        w_done_perr   = 1'b0;
        if (bit_en) begin
            case (r_state)
                HUNT: begin
                    if (w_history_shift == SYNC_PATTERN) begin
                        // Clear history so the next search never reuses these bits.
                        w_history_nxt = '0;
                        w_count_nxt   = '0;
                        w_state_nxt   = PAYLOAD;
                    end else begin
                        w_history_nxt = w_history_shift;
                    end
                end
                PAYLOAD: begin
                    w_payload_nxt = {r_payload[DATA_WIDTH-2:0], data_in};
                    w_count_nxt   = r_count + CW'(1);
                    if (r_count == CW'(DATA_WIDTH - 1)) begin
                        if (PARITY_EN) begin
                            w_state_nxt = PARITY;
                        end else begin
                            w_complete  = 1'b1;
                            w_done_data = w_payload_nxt;
                            w_state_nxt = HUNT;
                        end
                    end
                end
                PARITY: begin
                    w_complete  = 1'b1;
                    w_done_data = r_payload;
                    w_done_perr = ^{r_payload, data_in};
                    w_state_nxt = HUNT;
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // Datapath registers: sync history, payload shift register, bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_history <= '0;
            r_payload <= '0;
            r_count   <= '0;
        end else begin
            r_history <= w_history_nxt;
            r_payload <= w_payload_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Output slot: load on completion when free or being emptied, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_frame_valid || frame_ready) begin
                    r_frame_data  <= w_done_data;
                    r_parity_err  <= w_done_perr;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign parity_err  = r_parity_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state != HUNT);
    assign state_dbg   = r_state;

endmodule
